// File: rtl/dff_pipe_chain.sv
// Elastic register chain: DEPTH stages of DW bits, valid/ready at both ends,
// bubble collapse, global hold and synchronous flush to SET_VAL.
module dff_pipe_chain #(
    parameter int          DW      = 16,
    parameter int          DEPTH   = 3,
    parameter logic [DW-1:0] SET_VAL = {DW{1'b0}},
    parameter int          CW      = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hold_i,
    input  logic          flush_i,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic [CW-1:0] count_o
);

    logic [DEPTH-1:0] vld_p;
    logic [DW-1:0]    data_p [DEPTH];

    logic             run;
    logic             accept;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] fill;
    logic [DEPTH-1:0] vld_nxt;
    logic [DW-1:0]    din [DEPTH];

    function automatic logic [CW-1:0] popcnt(input logic [DEPTH-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int k = 0; k < DEPTH; k++) n = n + CW'(v[k]);
        return n;
    endfunction

    assign run = !hold_i && !flush_i;

    // Advance terms ripple from the output end back towards the input.
    always_comb begin
        adv = '0;
        if (run) begin
            adv[DEPTH-1] = vld_p[DEPTH-1] & out_ready;
            for (int k = DEPTH - 2; k >= 0; k--)
                adv[k] = vld_p[k] & (!vld_p[k+1] | adv[k+1]);
        end
    end

    assign in_ready = !rst && run && (!vld_p[0] || adv[0]);
    assign accept   = in_valid && in_ready;

    always_comb begin
        fill    = '0;
        vld_nxt = vld_p;
        din[0]  = in_data;
        fill[0] = accept;
        for (int k = 1; k < DEPTH; k++) begin
            din[k]  = data_p[k-1];
            fill[k] = adv[k-1];
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (flush_i)      vld_nxt[k] = 1'b0;
            else if (fill[k]) vld_nxt[k] = 1'b1;
            else if (adv[k])  vld_nxt[k] = 1'b0;
        end
    end

    // Stage registers; fill/adv are already masked by hold and flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p   <= '0;
            count_o <= '0;
            for (int k = 0; k < DEPTH; k++) data_p[k] <= SET_VAL;
        end else begin
            vld_p   <= vld_nxt;
            count_o <= popcnt(vld_nxt);
            for (int k = 0; k < DEPTH; k++) begin
                if (flush_i)      data_p[k] <= SET_VAL;
                else if (fill[k]) data_p[k] <= din[k];
            end
        end
    end

    assign out_valid = vld_p[DEPTH-1] && run;
    assign out_data  = data_p[DEPTH-1];

endmodule
